fetch_stage: RTL and testbench

//  Instruction-fetch stage of the 5-stage MIPS pipeline; drives the IF/ID register.
//  - Owns the PC and issues word reads to the icache.
//  - Applies stalls from the hazard unit and redirects from branches and jumps.
//  - Delivers the fetched instruction and PC+4 to IF/ID, or a bubble (valid=0, instr=0).

---
 rtl/fetch_stage.sv | 132 +++++++++++++
 tb/tb_fetch_stage.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, reads the icache and feeds IF/ID.
// Optional HALT detection is enabled with `define FETCH_HALT_DETECT_EN.
module fetch_stage #(
  parameter logic [31:0] PC_INIT = 32'h0000_0000,
  parameter logic [5:0]  HALT_OP = 6'h3F
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        ihit,
  input  logic [31:0] imemload,
  output logic        imemREN,
  output logic [31:0] imemaddr,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_addr,
  input  logic        jump_en,
  input  logic [31:0] jump_addr,
  output logic [31:0] instr,
  output logic [31:0] JALjump_addr,
  output logic        valid,
  output logic        halted
);

`ifdef FETCH_HALT_DETECT_EN
  typedef enum logic [1:0] {RUN = 2'b00, PEND = 2'b01, HALT = 2'b10} fetchState_t;
`else
  typedef enum logic [1:0] {RUN = 2'b00, PEND = 2'b01} fetchState_t;
`endif

  localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;

  fetchState_t state;
  logic [31:0] pc;
  logic [31:0] pendPc;
  logic [31:0] pcPlus4;
  logic [31:0] target;
  logic        redirect;

  // The branch is the older instruction, so it wins over a simultaneous jump.
  assign redirect = branch_taken | jump_en;
  assign target   = (branch_taken ? branch_addr : jump_addr) & WORD_MASK;
  assign pcPlus4  = pc + 32'd4;
  assign imemaddr = pc;

`ifdef FETCH_HALT_DETECT_EN
  assign imemREN = nRST && (state != HALT);
`else
  assign imemREN = nRST;
  assign halted  = 1'b0;
  logic unusedHaltOp;
  assign unusedHaltOp = ^HALT_OP;
`endif

  // NOTE: all state here is updated with non-blocking assignments so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state        <= RUN;
      pc           <= PC_INIT & WORD_MASK;
      pendPc       <= '0;
      instr        <= '0;
      JALjump_addr <= '0;
      valid        <= 1'b0;
`ifdef FETCH_HALT_DETECT_EN
      halted       <= 1'b0;
`endif
    end else begin
      case (state)
        RUN: begin
          if (redirect) begin
            instr        <= '0;
            JALjump_addr <= '0;
            valid        <= 1'b0;
            // A miss is still outstanding on the old pc; park the target.
            if (ihit) begin
              pc <= target;
            end else begin
              pendPc <= target;
              state  <= PEND;
            end
          end else if (ihit && !stall) begin
            instr        <= imemload;
            JALjump_addr <= pcPlus4;
            valid        <= 1'b1;
            pc           <= pcPlus4;
`ifdef FETCH_HALT_DETECT_EN
            if (imemload[31:26] == HALT_OP) begin
              state  <= HALT;
              halted <= 1'b1;
            end
`endif
          end else if (!ihit && !stall) begin
            instr        <= '0;
            JALjump_addr <= '0;
            valid        <= 1'b0;
          end
        end
        PEND: begin
          instr        <= '0;
          JALjump_addr <= '0;
          valid        <= 1'b0;
          if (ihit) begin
            pc    <= redirect ? target : pendPc;
            state <= RUN;
          end else if (redirect) begin
            pendPc <= target;
          end
        end
`ifdef FETCH_HALT_DETECT_EN
        HALT: begin
          instr        <= '0;
          JALjump_addr <= '0;
          valid        <= 1'b0;
          // Only a wrong-path HALT gets here with a redirect behind it.
          if (redirect) begin
            pc     <= target;
            halted <= 1'b0;
            state  <= RUN;
          end
        end
`endif
        default: begin
          state        <= RUN;
          instr        <= '0;
          JALjump_addr <= '0;
          valid        <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios with literal
// expectations, then randomized traffic against a behavioural model.
module tb_fetch_stage;
  localparam logic [31:0] PC_INIT_TB = 32'h0000_0043;
  localparam logic [5:0]  HALT_OP_TB = 6'h3F;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic        ihit = 1'b0;
  logic [31:0] imemload = '0;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_addr = '0;
  logic        jump_en = 1'b0;
  logic [31:0] jump_addr = '0;
  logic [31:0] instr;
  logic [31:0] JALjump_addr;
  logic        valid;
  logic        halted;

  int checks = 0;
  int errors = 0;
  logic rstReq = 1'b0;

  fetch_stage #(.PC_INIT(PC_INIT_TB), .HALT_OP(HALT_OP_TB)) dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .imemload(imemload),
    .imemREN(imemREN), .imemaddr(imemaddr), .stall(stall),
    .branch_taken(branch_taken), .branch_addr(branch_addr),
    .jump_en(jump_en), .jump_addr(jump_addr), .instr(instr),
    .JALjump_addr(JALjump_addr), .valid(valid), .halted(halted)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the PC, an optional parked redirect and a halted flag.
  logic [31:0] mPc, mPendPc, mInstr, mJal;
  logic        mPendValid, mValid, mHalted;
  bit          mKnown = 0;

  always @(posedge CLK) begin
    logic [31:0] tgt;
    logic        redir;
    logic        bubble;
    redir  = branch_taken | jump_en;
    tgt    = (branch_taken ? branch_addr : jump_addr) & 32'hFFFF_FFFC;
    bubble = 1'b0;
    if (!nRST) begin
      mPc = PC_INIT_TB & 32'hFFFF_FFFC;
      mPendValid = 0; mPendPc = 0; mHalted = 0;
      mInstr = 0; mJal = 0; mValid = 0;
      mKnown = 1;
    end else if (mKnown) begin
      if (mHalted) begin
        bubble = 1;
        if (redir) begin mPc = tgt; mHalted = 0; end
      end else if (mPendValid) begin
        bubble = 1;
        if (ihit) begin
          mPc = redir ? tgt : mPendPc;
          mPendValid = 0;
        end else if (redir) mPendPc = tgt;
      end else if (redir) begin
        bubble = 1;
        if (ihit) mPc = tgt;
        else begin mPendValid = 1; mPendPc = tgt; end
      end else if (ihit && !stall) begin
        mInstr = imemload;
        mJal   = mPc + 32'd4;
        mValid = 1;
        mPc    = mPc + 32'd4;
`ifdef FETCH_HALT_DETECT_EN
        if (imemload[31:26] == HALT_OP_TB) mHalted = 1;
`endif
      end else if (!ihit && !stall) bubble = 1;
      if (bubble) begin mInstr = 0; mJal = 0; mValid = 0; end
    end
    #1;
    if (mKnown) begin
      check("imemaddr", imemaddr, mPc);
      check("imemREN", {31'd0, imemREN}, {31'd0, nRST && !mHalted});
      check("instr", instr, mInstr);
      check("JALjump_addr", JALjump_addr, mJal);
      check("valid", {31'd0, valid}, {31'd0, mValid});
      check("halted", {31'd0, halted}, {31'd0, mHalted});
    end
  end

  task automatic step(input logic hit, input logic [31:0] load, input logic stl,
                      input logic bt, input logic [31:0] ba,
                      input logic je, input logic [31:0] ja);
    @(negedge CLK);
    nRST = rstReq; ihit = hit; imemload = load; stall = stl;
    branch_taken = bt; branch_addr = ba; jump_en = je; jump_addr = ja;
    @(posedge CLK);
    #2;
  endtask

  initial begin
    // Reset (PC_INIT low bits must be ignored: 0x43 -> 0x40).
    rstReq = 0;
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    check("rst_pc", imemaddr, 32'h40);
    check("rst_valid", {31'd0, valid}, 32'd0);
    check("rst_instr", instr, 32'd0);
    check("rst_ren", {31'd0, imemREN}, 32'd0);

    // Sequential fetch.
    rstReq = 1;
    step(1, 32'h1111_0000, 0, 0, 0, 0, 0);
    check("seq1_jal", JALjump_addr, 32'h44);
    check("seq1_valid", {31'd0, valid}, 32'd1);
    check("seq1_instr", instr, 32'h1111_0000);
    step(1, 32'h1111_0001, 0, 0, 0, 0, 0);
    check("seq2_jal", JALjump_addr, 32'h48);
    step(1, 32'h1111_0002, 0, 0, 0, 0, 0);
    check("seq3_jal", JALjump_addr, 32'h4C);
    check("seq3_pc", imemaddr, 32'h4C);

    // Stall with ihit holds everything; release advances by exactly 4.
    step(1, 32'h2222_0000, 1, 0, 0, 0, 0);
    step(1, 32'h2222_0001, 1, 0, 0, 0, 0);
    check("stall_pc", imemaddr, 32'h4C);
    check("stall_instr", instr, 32'h1111_0002);
    check("stall_valid", {31'd0, valid}, 32'd1);
    step(1, 32'h1111_0003, 0, 0, 0, 0, 0);
    check("unstall_pc", imemaddr, 32'h50);
    check("unstall_jal", JALjump_addr, 32'h50);

    // Jump during a miss waits for the outstanding word, which is dropped.
    step(0, 0, 0, 0, 0, 1, 32'h100);
    check("pend_pc", imemaddr, 32'h50);
    check("pend_valid", {31'd0, valid}, 32'd0);
    step(0, 0, 0, 0, 0, 0, 0);
    check("pend_hold", imemaddr, 32'h50);
    step(1, 32'h3333_0000, 0, 0, 0, 0, 0);
    check("pend_done_pc", imemaddr, 32'h100);
    check("pend_drop", {31'd0, valid}, 32'd0);
    step(1, 32'h1111_0005, 0, 0, 0, 0, 0);
    check("after_jump_jal", JALjump_addr, 32'h104);

    // Branch and jump together under stall: branch wins, bubble.
    step(1, 32'h4444_0000, 1, 1, 32'h200, 1, 32'h300);
    check("prio_pc", imemaddr, 32'h200);
    check("prio_valid", {31'd0, valid}, 32'd0);
    check("prio_instr", instr, 32'd0);

    // PC wrap.
    step(1, 32'h5555_0000, 0, 0, 0, 1, 32'hFFFF_FFFC);
    check("wrap_setup", imemaddr, 32'hFFFF_FFFC);
    step(1, 32'h1111_0008, 0, 0, 0, 0, 0);
    check("wrap_pc", imemaddr, 32'h0);
    check("wrap_jal", JALjump_addr, 32'h0);
    check("wrap_valid", {31'd0, valid}, 32'd1);

`ifdef FETCH_HALT_DETECT_EN
    step(1, 32'hFC00_0000, 0, 0, 0, 0, 0);
    check("halt_flag", {31'd0, halted}, 32'd1);
    check("halt_ren", {31'd0, imemREN}, 32'd0);
    check("halt_passed", instr, 32'hFC00_0000);
    step(1, 32'h1111_0009, 0, 0, 0, 0, 0);
    check("halt_bubble", {31'd0, valid}, 32'd0);
    check("halt_frozen", imemaddr, 32'h4);
    step(0, 0, 0, 0, 0, 1, 32'h80);
    check("unhalt_flag", {31'd0, halted}, 32'd0);
    check("unhalt_pc", imemaddr, 32'h80);
`endif

    // Reset while a redirect is parked on a miss: the target is lost.
    step(0, 0, 0, 0, 0, 1, 32'h120);
    rstReq = 0;
    step(0, 0, 0, 0, 0, 0, 0);
    check("midmiss_rst_pc", imemaddr, 32'h40);
    check("midmiss_rst_valid", {31'd0, valid}, 32'd0);
    rstReq = 1;
    step(0, 0, 0, 0, 0, 0, 0);
    check("no_stale_pend", imemaddr, 32'h40);
    step(1, 32'h1111_000A, 0, 0, 0, 0, 0);
    check("post_rst_jal", JALjump_addr, 32'h44);

    // Randomized traffic; the compare process checks every cycle.
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] load;
      load = $urandom;
      if ($urandom_range(0, 19) == 0) load[31:26] = HALT_OP_TB;
      rstReq = ($urandom_range(0, 99) != 0);
      step($urandom_range(0, 9) < 7, load, $urandom_range(0, 3) == 0,
           $urandom_range(0, 11) == 0, $urandom,
           $urandom_range(0, 11) == 0, $urandom);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
